// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//  Shared definitions for the interrupt controller: register byte offsets
//  within the 16-byte window, the GIE bit position in IMASK, the controller
//  state encoding and a small one-hot helper.
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam logic [3:0] OFS_IMASK  = 4'h0;
    localparam logic [3:0] OFS_IPEND  = 4'h4;
    localparam logic [3:0] OFS_ICAUSE = 4'h8;
    localparam logic [3:0] OFS_EPC    = 4'hC;

    localparam int GIE_BIT = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // One-hot decode of a 4-bit source id into a 16-bit vector.
    function automatic logic [15:0] id_onehot(input logic [3:0] id);
        id_onehot = 16'd1 << id;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
//  Combinational priority encoder, lowest index wins.
//  Ports:
//   req    in   NUM_SRC  candidate request vector
//   valid  out  1        at least one request bit set
//   id     out  4        index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [3:0]         id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end else begin
                valid = valid;
                id    = id;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//  Edge-captures peripheral IRQ lines into a pending register, masks and
//  prioritises them (lowest index first) and requests an interrupt from the
//  CPU pipeline through a req/ack handshake. Holds EPC and cause until eret.
//  Ports:
//   clk, reset            clock, synchronous active-low reset
//   irq_src               level IRQ inputs (bit 0 = timer)
//   Address/Write_data/MemWrite/MemRead/Read_data   memory-mapped bus
//   pc_kernel             1 blocks new requests
//   epc_in                resume PC captured on irq_ack
//   irq_req/irq_ack       request handshake with the pipeline
//   irq_id                requested / serviced source index
//   irq_vector            handler entry PC (constant)
//   eret                  handler return strobe
//   EPC                   saved resume PC
//  Registers at BASE_ADDR: +0 IMASK, +4 IPEND (W1C), +8 ICAUSE, +C EPC.
// ---------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0020,
    parameter logic [31:0] VECTOR    = 32'h8000_0004
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        Address,
    input  logic [31:0]        Write_data,
    input  logic               MemWrite,
    input  logic               MemRead,
    output logic [31:0]        Read_data,
    input  logic               pc_kernel,
    input  logic [31:0]        epc_in,
    output logic               irq_req,
    input  logic               irq_ack,
    output logic [3:0]         irq_id,
    output logic [31:0]        irq_vector,
    input  logic               eret,
    output logic [31:0]        EPC
);

    irq_state_e         state_r, state_n_s;
    logic [NUM_SRC-1:0] src_q_r;
    logic [NUM_SRC-1:0] en_r;
    logic               gie_r;
    logic [NUM_SRC-1:0] ipend_r, ipend_n_s;
    logic [3:0]         icause_r;
    logic [31:0]        epc_r;
    logic [3:0]         irq_id_r;

    logic               sel_s;
    logic [3:0]         ofs_s;
    logic               wr_imask_s, wr_ipend_s;
    logic [NUM_SRC-1:0] rise_s, w1c_s, ack_clr_s, elig_vec_s;
    logic [15:0]        elig16_s, id_oh_s;
    logic               prio_valid_s;
    logic [3:0]         prio_id_s;
    logic               eligible_s, latched_ok_s, ack_take_s, irq_req_s;
    logic [31:0]        imask_rd_s;
    logic               unused_s;

    // Bus window decode: 16-byte aligned block, low nibble selects the register.
    assign sel_s      = (Address[31:4] == BASE_ADDR[31:4]);
    assign ofs_s      = Address[3:0];
    assign wr_imask_s = MemWrite & sel_s & (ofs_s == OFS_IMASK);
    assign wr_ipend_s = MemWrite & sel_s & (ofs_s == OFS_IPEND);

    assign rise_s     = irq_src & ~src_q_r;
    assign w1c_s      = wr_ipend_s ? Write_data[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign elig_vec_s = ipend_r & en_r;
    assign elig16_s   = 16'(elig_vec_s);
    assign id_oh_s    = id_onehot(irq_id_r);

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req   (elig_vec_s),
        .valid (prio_valid_s),
        .id    (prio_id_s)
    );

    assign eligible_s   = gie_r & prio_valid_s;
    // The request stays valid only while its own latched source is still eligible.
    assign latched_ok_s = gie_r & elig16_s[irq_id_r];
    assign ack_take_s   = (state_r == REQ) & irq_ack;
    assign ack_clr_s    = ack_take_s ? id_oh_s[NUM_SRC-1:0] : {NUM_SRC{1'b0}};

    // Pending next value: W1C first, then new edges (set wins), then ack clear wins over all.
    assign ipend_n_s = ((ipend_r & ~w1c_s) | rise_s) & ~ack_clr_s;

    // Next-state and request output for the handshake state machine.
    always_comb begin
        state_n_s = state_r;
        irq_req_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (eligible_s && !pc_kernel) begin
                    state_n_s = REQ;
                end else begin
                    state_n_s = IDLE;
                end
            end
            REQ: begin
                irq_req_s = latched_ok_s;
                if (irq_ack) begin
                    state_n_s = SERVICE;
                end else if (!latched_ok_s) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = REQ;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = SERVICE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Edge detector history; loaded during reset too so a level held high
    // across reset is not seen as a fresh edge afterwards.
    always_ff @(posedge clk) begin
        src_q_r <= irq_src;
    end

    // Controller state, registers and captured context.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            en_r     <= {NUM_SRC{1'b0}};
            gie_r    <= 1'b0;
            ipend_r  <= {NUM_SRC{1'b0}};
            icause_r <= 4'd0;
            epc_r    <= 32'd0;
            irq_id_r <= 4'd0;
        end else begin
            state_r <= state_n_s;
            ipend_r <= ipend_n_s;
            if (wr_imask_s) begin
                en_r  <= Write_data[NUM_SRC-1:0];
                gie_r <= Write_data[GIE_BIT];
            end
            if ((state_r == IDLE) && (state_n_s == REQ)) begin
                irq_id_r <= prio_id_s;
            end
            if (ack_take_s) begin
                epc_r    <= epc_in;
                icause_r <= irq_id_r;
            end
        end
    end

    // IMASK read image: enables in the low bits, GIE at the top.
    always_comb begin
        imask_rd_s                 = 32'd0;
        imask_rd_s[NUM_SRC-1:0]    = en_r;
        imask_rd_s[GIE_BIT]        = gie_r;
    end

    // Combinational read mux; zero whenever not reading a mapped register.
    always_comb begin
        Read_data = 32'd0;
        if (MemRead && sel_s) begin
            case (ofs_s)
                OFS_IMASK:  Read_data = imask_rd_s;
                OFS_IPEND:  Read_data = 32'(ipend_r);
                OFS_ICAUSE: Read_data = {28'd0, icause_r};
                OFS_EPC:    Read_data = epc_r;
                default:    Read_data = 32'd0;
            endcase
        end else begin
            Read_data = 32'd0;
        end
    end

    assign irq_req    = irq_req_s;
    assign irq_id     = irq_id_r;
    assign irq_vector = VECTOR;
    assign EPC        = epc_r;

    // Bits intentionally not consumed (upper write data, one-hot tail).
    assign unused_s = ^{Write_data, id_oh_s};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// traffic, all checked every cycle against a behavioural reference model.
module tb_irq_controller;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0020;
    localparam logic [31:0] VEC  = 32'h8000_0004;
    localparam int P_IDLE = 0, P_REQ = 1, P_SVC = 2;

    logic          clk, reset;
    logic [N-1:0]  irq_src;
    logic [31:0]   Address, Write_data, Read_data, epc_in, irq_vector, EPC;
    logic          MemWrite, MemRead, pc_kernel, irq_req, irq_ack, eret;
    logic [3:0]    irq_id;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [N-1:0] m_mask, m_pend, m_prev;
    logic         m_gie;
    logic [31:0]  m_epc;
    int           m_cause, m_id, m_phase;

    irq_controller #(.NUM_SRC(N), .BASE_ADDR(BASE), .VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .Address(Address),
        .Write_data(Write_data), .MemWrite(MemWrite), .MemRead(MemRead),
        .Read_data(Read_data), .pc_kernel(pc_kernel), .epc_in(epc_in),
        .irq_req(irq_req), .irq_ack(irq_ack), .irq_id(irq_id),
        .irq_vector(irq_vector), .eret(eret), .EPC(EPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic model_req();
        return (m_phase == P_REQ) && m_gie && m_pend[m_id] && m_mask[m_id];
    endfunction

    function automatic logic [31:0] model_rd();
        logic [31:0] d;
        if (!MemRead || Address < BASE || Address >= BASE + 32'd16 || Address[1:0] != 2'd0)
            return 32'd0;
        case ((Address - BASE) / 32'd4)
            32'd0: begin d = 32'(m_mask); d[31] = m_gie; return d; end
            32'd1: return 32'(m_pend);
            32'd2: return 32'(m_cause);
            default: return m_epc;
        endcase
    endfunction

    task automatic model_next();
        logic [N-1:0] w1c, nxt;
        int sel;
        if (!reset) begin
            m_mask = '0; m_gie = 1'b0; m_pend = '0; m_epc = 32'd0;
            m_cause = 0; m_id = 0; m_phase = P_IDLE; m_prev = irq_src;
            return;
        end
        w1c = (MemWrite && Address == BASE + 32'd4) ? Write_data[N-1:0] : '0;
        nxt = (m_pend & ~w1c) | (irq_src & ~m_prev);
        case (m_phase)
            P_IDLE: begin
                sel = lowest(m_pend & m_mask);
                if (m_gie && sel >= 0 && !pc_kernel) begin
                    m_phase = P_REQ;
                    m_id = sel;
                end
            end
            P_REQ: begin
                if (irq_ack) begin
                    m_epc = epc_in; m_cause = m_id; nxt[m_id] = 1'b0; m_phase = P_SVC;
                end else if (!model_req()) begin
                    m_phase = P_IDLE;
                end
            end
            default: if (eret) m_phase = P_IDLE;
        endcase
        if (MemWrite && Address == BASE) begin
            m_mask = Write_data[N-1:0];
            m_gie  = Write_data[31];
        end
        m_pend = nxt;
        m_prev = irq_src;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, pass the edge.
    task automatic cycle();
        @(negedge clk);
        chk_eq("irq_req", 32'(irq_req), 32'(model_req()));
        chk_eq("irq_id", 32'(irq_id), 32'(m_id));
        chk_eq("EPC", EPC, m_epc);
        chk_eq("irq_vector", irq_vector, VEC);
        chk_eq("Read_data", Read_data, model_rd());
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address = addr; Write_data = data; MemWrite = 1'b1;
        cycle();
        MemWrite = 1'b0;
    endtask

    task automatic bus_read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr; MemRead = 1'b1;
        #1;
        chk_eq(tag, Read_data, exp);
        cycle();
        MemRead = 1'b0;
    endtask

    task automatic ack_and_return(input logic [31:0] pc);
        irq_ack = 1'b1; epc_in = pc;
        cycle();
        irq_ack = 1'b0;
        eret = 1'b1;
        cycle();
        eret = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int k = 0;
        while (!irq_req && k < budget) begin
            cycle();
            k++;
        end
        chk_eq(tag, 32'(irq_req), 32'd1);
    endtask

    initial begin
        m_mask = '0; m_pend = '0; m_prev = '0; m_gie = 1'b0; m_epc = 32'd0;
        m_cause = 0; m_id = 0; m_phase = P_IDLE;
        reset = 1'b0; irq_src = '0; Address = 32'd0; Write_data = 32'd0;
        MemWrite = 1'b0; MemRead = 1'b0; pc_kernel = 1'b0; epc_in = 32'd0;
        irq_ack = 1'b0; eret = 1'b0;

        // 1: reset, all registers zero
        cycle(); cycle();
        reset = 1'b1;
        chk_eq("t1_req", 32'(irq_req), 32'd0);
        bus_read_chk("t1_imask", BASE, 32'd0);
        bus_read_chk("t1_ipend", BASE + 32'd4, 32'd0);
        bus_read_chk("t1_icause", BASE + 32'd8, 32'd0);
        bus_read_chk("t1_epc", BASE + 32'hC, 32'd0);

        // 2: basic latency and handshake on the timer source
        bus_write(BASE, 32'h8000_0001);
        irq_src = 4'b0001;
        cycle();
        irq_src = 4'b0000;
        chk_eq("t2_req_n1", 32'(irq_req), 32'd0);
        bus_read_chk("t2_ipend_n1", BASE + 32'd4, 32'd1);
        chk_eq("t2_req_n2", 32'(irq_req), 32'd1);
        chk_eq("t2_id", 32'(irq_id), 32'd0);
        irq_ack = 1'b1; epc_in = 32'h0040_0010;
        cycle();
        irq_ack = 1'b0;
        chk_eq("t2_epc", EPC, 32'h0040_0010);
        chk_eq("t2_req_svc", 32'(irq_req), 32'd0);
        bus_read_chk("t2_icause", BASE + 32'd8, 32'd0);
        bus_read_chk("t2_ipend_clr", BASE + 32'd4, 32'd0);
        eret = 1'b1; cycle(); eret = 1'b0;
        cycle();

        // 3: simultaneous edges, lowest index first, then the other
        bus_write(BASE, 32'h8000_0006);
        irq_src = 4'b0110;
        cycle();
        irq_src = 4'b0000;
        cycle();
        chk_eq("t3_req", 32'(irq_req), 32'd1);
        chk_eq("t3_id1", 32'(irq_id), 32'd1);
        ack_and_return(32'h0040_0100);
        wait_req("t3_second_req", 8);
        chk_eq("t3_id2", 32'(irq_id), 32'd2);
        ack_and_return(32'h0040_0200);
        bus_read_chk("t3_icause", BASE + 32'd8, 32'd2);

        // 4: kernel mode blocks requests
        bus_write(BASE, 32'h8000_0001);
        pc_kernel = 1'b1;
        irq_src = 4'b0001;
        cycle();
        irq_src = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            chk_eq("t4_blocked", 32'(irq_req), 32'd0);
            cycle();
        end
        pc_kernel = 1'b0;
        chk_eq("t4_still_low", 32'(irq_req), 32'd0);
        cycle();
        chk_eq("t4_req", 32'(irq_req), 32'd1);
        ack_and_return(32'h0040_0300);

        // 5: W1C withdraws a pending request; edge coinciding with W1C wins
        irq_src = 4'b0001;
        cycle();
        irq_src = 4'b0000;
        cycle();
        chk_eq("t5_req", 32'(irq_req), 32'd1);
        bus_write(BASE + 32'd4, 32'd1);
        chk_eq("t5_req_drop", 32'(irq_req), 32'd0);
        cycle();
        bus_read_chk("t5_ipend_clr", BASE + 32'd4, 32'd0);
        bus_write(BASE, 32'h0000_0001);
        irq_src = 4'b0001;
        bus_write(BASE + 32'd4, 32'd1);
        irq_src = 4'b0000;
        bus_read_chk("t5_set_wins", BASE + 32'd4, 32'd1);
        bus_write(BASE + 32'd4, 32'd1);
        bus_read_chk("t5_ipend_end", BASE + 32'd4, 32'd0);

        // 6: levels held across reset do not re-pend; unmapped read
        irq_src = 4'hF;
        bus_write(BASE, 32'h8000_000F);
        cycle(); cycle(); cycle();
        reset = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle(); cycle(); cycle();
        bus_read_chk("t6_ipend", BASE + 32'd4, 32'd0);
        chk_eq("t6_req", 32'(irq_req), 32'd0);
        bus_read_chk("t6_unmapped", BASE + 32'h10, 32'd0);
        irq_src = 4'h0;
        cycle();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            irq_src   = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            pc_kernel = ($urandom_range(0, 9) < 2);
            irq_ack   = ($urandom_range(0, 9) < 3);
            eret      = ($urandom_range(0, 9) < 2);
            epc_in    = $urandom;
            reset     = ($urandom_range(0, 499) != 0);
            MemWrite  = 1'b0;
            MemRead   = ($urandom_range(0, 1) == 1);
            Address   = BASE - 32'd4 + 32'($urandom_range(0, 23));
            Write_data = $urandom;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                MemWrite = 1'b1; Address = BASE;
                Write_data = {($urandom_range(0, 3) != 0), 27'd0, 4'($urandom)};
            end else if (r == 1) begin
                MemWrite = 1'b1; Address = BASE + 32'd4;
            end else if (r == 2) begin
                MemWrite = 1'b1;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
